// File: rtl/stagger_ctrl.sv
// stagger_ctrl: sequencing controller for a staggered X-engine datapath.
// Block p of the bank sits max(p-STAGGER_OFFSET,0) clocks behind block 0.
// This controller:
//   - accepts framed words (vld_in/sync_in),
//   - produces per-stage valid/sync vectors aligned to each block,
//   - holds off upstream while the deepest stage drains,
//   - pulses frame_done once the last word has left the deepest stage.
// Optional build macro: STAGGER_CTRL_ERR_EN adds the err_sticky/err_cnt
// protocol-violation outputs.
module stagger_ctrl #(
  parameter int N_STAGES       = 4,
  parameter int STAGGER_OFFSET = 0,
  parameter int FRAME_LEN      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vld_in,
  input  logic                sync_in,
  output logic                rdy_out,
  output logic [N_STAGES-1:0] stage_vld,
  output logic [N_STAGES-1:0] stage_sync,
  output logic                busy,
  output logic                frame_done
`ifdef STAGGER_CTRL_ERR_EN
  ,
  output logic                err_sticky,
  output logic [7:0]          err_cnt
`endif
);

  // Depth of the deepest stage relative to the undelayed ones
  localparam int D   = ((N_STAGES - 1 - STAGGER_OFFSET) > 0) ? (N_STAGES - 1 - STAGGER_OFFSET) : 0;
  localparam int WCW = $clog2(FRAME_LEN + 1);
  localparam int DCW = (D > 0) ? $clog2(D + 1) : 1;

  localparam logic [WCW-1:0] LAST_WORD  = WCW'(FRAME_LEN);
  localparam logic [DCW-1:0] DRAIN_INIT = DCW'(D);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           frame_done_q, frame_done_d;

  logic           accept_s;
  logic           acc_vld_s;
  logic           acc_sync_s;
  logic           last_word_s;
  logic [WCW-1:0] word_inc_s;

  // Ready is a pure function of state; held low while reset is asserted so
  // nothing can leak through the undelayed stages during reset.
  assign rdy_out    = ~rst & (state_q != DRAIN);
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

  // In IDLE only a sync word opens a frame; a bare word there is dropped.
  // In RUN every accepted word is data and sync_in is ignored.
  assign accept_s   = vld_in & rdy_out;
  assign acc_vld_s  = accept_s & ((state_q != IDLE) | sync_in);
  assign acc_sync_s = accept_s & sync_in & (state_q == IDLE);
  assign word_inc_s = word_cnt_q + {{(WCW-1){1'b0}}, 1'b1};

  // Next-state logic: frame word counting, drain countdown, completion
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    frame_done_d = 1'b0;
    last_word_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (acc_sync_s) begin
          word_cnt_d = {{(WCW-1){1'b0}}, 1'b1};
          if (FRAME_LEN == 1) begin
            last_word_s = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          word_cnt_d = {WCW{1'b0}};
        end
      end
      RUN: begin
        if (accept_s) begin
          word_cnt_d = word_inc_s;
          if (word_inc_s == LAST_WORD) begin
            last_word_s = 1'b1;
          end else begin
            last_word_s = 1'b0;
          end
        end else begin
          word_cnt_d = word_cnt_q;
        end
      end
      DRAIN: begin
        if (drain_cnt_q <= {{(DCW-1){1'b0}}, 1'b1}) begin
          state_d      = IDLE;
          drain_cnt_d  = {DCW{1'b0}};
          frame_done_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - {{(DCW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d     = IDLE;
        word_cnt_d  = {WCW{1'b0}};
        drain_cnt_d = {DCW{1'b0}};
      end
    endcase

    // Final word of the frame: either drain the stagger or, with no
    // stagger depth, finish immediately so a new sync can follow at once.
    if (last_word_s) begin
      word_cnt_d = {WCW{1'b0}};
      if (D == 0) begin
        state_d      = IDLE;
        frame_done_d = 1'b1;
      end else begin
        state_d     = DRAIN;
        drain_cnt_d = DRAIN_INIT;
      end
    end else begin
      frame_done_d = frame_done_d;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      word_cnt_q   <= {WCW{1'b0}};
      drain_cnt_q  <= {DCW{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  generate
    if (D > 0) begin : g_shift
      // Tap k of the chain carries acc_vld/acc_sync delayed by k clocks
      logic [D:1] sh_vld_q;
      logic [D:1] sh_sync_q;

      // Free-running alignment chain, shifts every cycle in every state
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sh_vld_q  <= {D{1'b0}};
          sh_sync_q <= {D{1'b0}};
        end else begin
          sh_vld_q[1]  <= acc_vld_s;
          sh_sync_q[1] <= acc_sync_s;
          for (int k = 2; k <= D; k++) begin
            sh_vld_q[k]  <= sh_vld_q[k-1];
            sh_sync_q[k] <= sh_sync_q[k-1];
          end
        end
      end

      for (genvar p = 0; p < N_STAGES; p++) begin : g_stage
        if (p <= STAGGER_OFFSET) begin : g_direct
          assign stage_vld[p]  = acc_vld_s;
          assign stage_sync[p] = acc_sync_s;
        end else begin : g_delayed
          assign stage_vld[p]  = sh_vld_q[p - STAGGER_OFFSET];
          assign stage_sync[p] = sh_sync_q[p - STAGGER_OFFSET];
        end
      end
    end else begin : g_noshift
      assign stage_vld  = {N_STAGES{acc_vld_s}};
      assign stage_sync = {N_STAGES{acc_sync_s}};
    end
  endgenerate

`ifdef STAGGER_CTRL_ERR_EN
  logic       viol_s;
  logic       err_sticky_q;
  logic [7:0] err_cnt_q;

  // Any of the three upstream protocol violations; several at once count once
  assign viol_s = vld_in & (~rdy_out
                            | ((state_q == IDLE) & ~sync_in)
                            | ((state_q == RUN) & sync_in));

  // Sticky flag and saturating violation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else if (viol_s) begin
      err_sticky_q <= 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end else begin
        err_cnt_q <= err_cnt_q;
      end
    end else begin
      err_sticky_q <= err_sticky_q;
      err_cnt_q    <= err_cnt_q;
    end
  end

  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
`endif

endmodule
